// File: rtl/initialization_sequencer_pkg.sv
// Shared types and bit positions for the 8259A initialization sequencer.
package init_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ICW2,
    WAIT_ICW3,
    WAIT_ICW4,
    READY
  } init_state_t;

  // Bit positions inside the command bytes
  localparam int unsigned ICW1_IC4  = 0;
  localparam int unsigned ICW1_SNGL = 1;
  localparam int unsigned ICW1_LTIM = 3;
  localparam int unsigned ICW1_SEL  = 4;
  localparam int unsigned OCW3_SEL  = 3;

endpackage

// File: rtl/initialization_sequencer_write_completion_detector.sv
// Detects the end of a CPU write and holds the last address/data seen while it was active.
// Optional feature: define INIT_SEQ_WR_SYNC_EN to pass the bus inputs through a two-flop synchronizer.
module write_completion_detector (
  input  logic       clock,
  input  logic       reset,
  input  logic       chip_select_n,
  input  logic       write_enable_n,
  input  logic       address,
  input  logic [7:0] data_bus_in,
  output logic       write_done,
  output logic       captured_address,
  output logic [7:0] captured_data
);

  logic       w_cs_n;
  logic       w_we_n;
  logic       w_addr;
  logic [7:0] w_data;
  logic       w_settled;
  logic       w_active;

`ifdef INIT_SEQ_WR_SYNC_EN
  logic [1:0] r_cs_n_sync;
  logic [1:0] r_we_n_sync;
  logic [1:0] r_addr_sync;
  logic [7:0] r_data_s1;
  logic [7:0] r_data_s2;
  logic [1:0] r_settle;

  // Two-flop synchronizer; r_settle marks when the synchronized view reflects post-reset inputs
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cs_n_sync <= '1;
      r_we_n_sync <= '1;
      r_addr_sync <= '0;
      r_data_s1   <= '0;
      r_data_s2   <= '0;
      r_settle    <= '0;
    end else begin
      r_cs_n_sync <= {r_cs_n_sync[0], chip_select_n};
      r_we_n_sync <= {r_we_n_sync[0], write_enable_n};
      r_addr_sync <= {r_addr_sync[0], address};
      r_data_s1   <= data_bus_in;
      r_data_s2   <= r_data_s1;
      r_settle    <= {r_settle[0], 1'b1};
    end
  end

  assign w_cs_n    = r_cs_n_sync[1];
  assign w_we_n    = r_we_n_sync[1];
  assign w_addr    = r_addr_sync[1];
  assign w_data    = r_data_s2;
  assign w_settled = r_settle[1];
`else
  assign w_cs_n    = chip_select_n;
  assign w_we_n    = write_enable_n;
  assign w_addr    = address;
  assign w_data    = data_bus_in;
  assign w_settled = 1'b1;
`endif

  assign w_active = ~w_cs_n & ~w_we_n;

  logic       r_active_d;
  logic       r_ignore;
  logic       r_addr;
  logic [7:0] r_data;

  // Capture bus every active cycle; a write already in progress at reset release
  // is ignored (r_ignore) until the bus has been seen idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_active_d <= 1'b0;
      r_ignore   <= 1'b1;
      r_addr     <= 1'b0;
      r_data     <= '0;
    end else begin
      r_active_d <= w_active & ~r_ignore;
      if (w_settled && !w_active) r_ignore <= 1'b0;
      if (w_active) begin
        r_addr <= w_addr;
        r_data <= w_data;
      end
    end
  end

  assign write_done       = r_active_d & ~w_active;
  assign captured_address = r_addr;
  assign captured_data    = r_data;

endmodule

// File: rtl/initialization_sequencer.sv
// 8259A host-write sequencer: decodes completed writes into ICW1-4 / OCW1-3 strobes
// and tracks the ICW initialization order.
// Optional feature: INIT_SEQ_WR_SYNC_EN (input synchronizer in write_completion_detector).
module initialization_sequencer (
  input  logic       clock,
  input  logic       reset,
  input  logic       chip_select_n,
  input  logic       write_enable_n,
  input  logic       address,
  input  logic [7:0] data_bus_in,
  output logic [7:0] internal_data_bus,
  output logic       write_initial_command_word_1,
  output logic       write_initial_command_word_2,
  output logic       write_initial_command_word_3,
  output logic       write_initial_command_word_4,
  output logic       write_operation_control_word_1,
  output logic       write_operation_control_word_2,
  output logic       write_operation_control_word_3,
  output logic       single_mode_config,
  output logic       icw4_required,
  output logic       level_triggered_config,
  output logic       initialization_done,
  output logic       sequence_error
);
  import init_sequencer_pkg::*;

  logic       w_write_done;
  logic       w_cap_addr;
  logic [7:0] w_cap_data;

  write_completion_detector u_detect (
    .clock            (clock),
    .reset            (reset),
    .chip_select_n    (chip_select_n),
    .write_enable_n   (write_enable_n),
    .address          (address),
    .data_bus_in      (data_bus_in),
    .write_done       (w_write_done),
    .captured_address (w_cap_addr),
    .captured_data    (w_cap_data)
  );

  init_state_t r_state, w_state_next;
  logic [7:0]  r_bus, w_bus;
  logic        r_icw1, r_icw2, r_icw3, r_icw4, r_ocw1, r_ocw2, r_ocw3;
  logic        w_icw1, w_icw2, w_icw3, w_icw4, w_ocw1, w_ocw2, w_ocw3;
  logic        r_sngl, r_ic4, r_ltim, r_err;
  logic        w_sngl, w_ic4, w_ltim, w_err;

  // State, strobes and latched configuration registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_bus   <= '0;
      r_icw1  <= 1'b0;
      r_icw2  <= 1'b0;
      r_icw3  <= 1'b0;
      r_icw4  <= 1'b0;
      r_ocw1  <= 1'b0;
      r_ocw2  <= 1'b0;
      r_ocw3  <= 1'b0;
      r_sngl  <= 1'b0;
      r_ic4   <= 1'b0;
      r_ltim  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_bus   <= w_bus;
      r_icw1  <= w_icw1;
      r_icw2  <= w_icw2;
      r_icw3  <= w_icw3;
      r_icw4  <= w_icw4;
      r_ocw1  <= w_ocw1;
      r_ocw2  <= w_ocw2;
      r_ocw3  <= w_ocw3;
      r_sngl  <= w_sngl;
      r_ic4   <= w_ic4;
      r_ltim  <= w_ltim;
      r_err   <= w_err;
    end
  end

  // Decode a completed write against the current sequence position
  always_comb begin
    w_state_next = r_state;
    w_bus        = r_bus;
    w_icw1       = 1'b0;
    w_icw2       = 1'b0;
    w_icw3       = 1'b0;
    w_icw4       = 1'b0;
    w_ocw1       = 1'b0;
    w_ocw2       = 1'b0;
    w_ocw3       = 1'b0;
    w_sngl       = r_sngl;
    w_ic4        = r_ic4;
    w_ltim       = r_ltim;
    w_err        = r_err;
    if (w_write_done) begin
      w_bus = w_cap_data;
      if (!w_cap_addr && w_cap_data[ICW1_SEL]) begin
        w_icw1       = 1'b1;
        w_sngl       = w_cap_data[ICW1_SNGL];
        w_ic4        = w_cap_data[ICW1_IC4];
        w_ltim       = w_cap_data[ICW1_LTIM];
        w_err        = 1'b0;
        w_state_next = WAIT_ICW2;
      end else begin
        unique case (r_state)
          IDLE: w_err = 1'b1;
          WAIT_ICW2: begin
            if (w_cap_addr) begin
              w_icw2 = 1'b1;
              if (!r_sngl)    w_state_next = WAIT_ICW3;
              else if (r_ic4) w_state_next = WAIT_ICW4;
              else            w_state_next = READY;
            end else begin
              w_err = 1'b1;
            end
          end
          WAIT_ICW3: begin
            if (w_cap_addr) begin
              w_icw3       = 1'b1;
              w_state_next = r_ic4 ? WAIT_ICW4 : READY;
            end else begin
              w_err = 1'b1;
            end
          end
          WAIT_ICW4: begin
            if (w_cap_addr) begin
              w_icw4       = 1'b1;
              w_state_next = READY;
            end else begin
              w_err = 1'b1;
            end
          end
          READY: begin
            if (w_cap_addr)                 w_ocw1 = 1'b1;
            else if (w_cap_data[OCW3_SEL])  w_ocw3 = 1'b1;
            else                            w_ocw2 = 1'b1;
          end
          default: w_state_next = IDLE;
        endcase
      end
    end
  end

  assign internal_data_bus              = r_bus;
  assign write_initial_command_word_1   = r_icw1;
  assign write_initial_command_word_2   = r_icw2;
  assign write_initial_command_word_3   = r_icw3;
  assign write_initial_command_word_4   = r_icw4;
  assign write_operation_control_word_1 = r_ocw1;
  assign write_operation_control_word_2 = r_ocw2;
  assign write_operation_control_word_3 = r_ocw3;
  assign single_mode_config             = r_sngl;
  assign icw4_required                  = r_ic4;
  assign level_triggered_config         = r_ltim;
  assign initialization_done            = (r_state == READY);
  assign sequence_error                 = r_err;

endmodule

// File: tb/tb_initialization_sequencer.sv
// Self-checking bench for initialization_sequencer: directed test-plan steps followed by
// randomized writes, compared every cycle against a queue-based protocol model.
module tb_initialization_sequencer;

`ifdef INIT_SEQ_WR_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clock;
  logic       reset;
  logic       chip_select_n;
  logic       write_enable_n;
  logic       address;
  logic [7:0] data_bus_in;
  logic [7:0] internal_data_bus;
  logic       icw1, icw2, icw3, icw4, ocw1, ocw2, ocw3;
  logic       single_mode_config, icw4_required, level_triggered_config;
  logic       initialization_done, sequence_error;

  initialization_sequencer dut (
    .clock                          (clock),
    .reset                          (reset),
    .chip_select_n                  (chip_select_n),
    .write_enable_n                 (write_enable_n),
    .address                        (address),
    .data_bus_in                    (data_bus_in),
    .internal_data_bus              (internal_data_bus),
    .write_initial_command_word_1   (icw1),
    .write_initial_command_word_2   (icw2),
    .write_initial_command_word_3   (icw3),
    .write_initial_command_word_4   (icw4),
    .write_operation_control_word_1 (ocw1),
    .write_operation_control_word_2 (ocw2),
    .write_operation_control_word_3 (ocw3),
    .single_mode_config             (single_mode_config),
    .icw4_required                  (icw4_required),
    .level_triggered_config         (level_triggered_config),
    .initialization_done            (initialization_done),
    .sequence_error                 (sequence_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Expected observable state; stb is the one-hot strobe vector {ICW1..ICW4, OCW1..OCW3}
  typedef struct packed {
    logic [6:0] stb;
    logic [7:0] bus;
    logic       sngl;
    logic       ic4;
    logic       ltim;
    logic       done;
    logic       err;
  } exp_t;

  exp_t exp_at [int];

  // Protocol model: list of ICW numbers still owed after the last ICW1
  bit         m_inited;
  int         m_pending [$];
  logic       m_sngl, m_ic4, m_ltim, m_err;
  logic [7:0] m_bus;

  function automatic void model_reset();
    m_inited = 1'b0;
    m_pending.delete();
    m_sngl = 1'b0; m_ic4 = 1'b0; m_ltim = 1'b0; m_err = 1'b0;
    m_bus  = 8'h00;
  endfunction

  // Returns the strobe number (1-4 ICW, 5-7 OCW) or 0 for a dropped write
  function automatic int model_write(logic a0, logic [7:0] d);
    m_bus = d;
    if (!a0 && d[4]) begin
      m_inited = 1'b1;
      m_sngl = d[1]; m_ic4 = d[0]; m_ltim = d[3]; m_err = 1'b0;
      m_pending.delete();
      m_pending.push_back(2);
      if (!d[1]) m_pending.push_back(3);
      if (d[0])  m_pending.push_back(4);
      return 1;
    end
    if (!m_inited) begin
      m_err = 1'b1;
      return 0;
    end
    if (m_pending.size() > 0) begin
      if (a0) return m_pending.pop_front();
      m_err = 1'b1;
      return 0;
    end
    if (a0) return 5;
    return d[3] ? 7 : 6;
  endfunction

  function automatic exp_t model_snapshot(int k);
    exp_t e;
    e.stb  = (k > 0) ? 7'(7'b1 << (7 - k)) : 7'b0;
    e.bus  = m_bus;
    e.sngl = m_sngl;
    e.ic4  = m_ic4;
    e.ltim = m_ltim;
    e.done = m_inited && (m_pending.size() == 0);
    e.err  = m_err;
    return e;
  endfunction

  // Per-cycle checker
  int         n_cmp  = 0;
  int         n_fail = 0;
  bit         mon_en = 1'b0;
  exp_t       cur    = '0;
  logic [6:0] es;

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, expv);
    end
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      es = '0;
      if (exp_at.exists(cyc)) begin
        cur = exp_at[cyc];
        es  = cur.stb;
      end
      chk("strobes", {1'b0, icw1, icw2, icw3, icw4, ocw1, ocw2, ocw3}, {1'b0, es});
      chk("data_bus", internal_data_bus, cur.bus);
      chk("config", {5'b0, single_mode_config, icw4_required, level_triggered_config},
          {5'b0, cur.sngl, cur.ic4, cur.ltim});
      chk("init_done", {7'b0, initialization_done}, {7'b0, cur.done});
      chk("seq_error", {7'b0, sequence_error}, {7'b0, cur.err});
    end
  end

  task automatic idle(int n);
    repeat (n) @(negedge clock);
  endtask

  // One CPU write: n active cycles (bus noise before the final one), ended by WE# or CS# rising
  task automatic wr(logic a0, logic [7:0] d, int n, bit cs_end);
    int k;
    for (int i = 0; i < n; i++) begin
      chip_select_n  = 1'b0;
      write_enable_n = 1'b0;
      address        = (i == n - 1) ? a0 : 1'($urandom);
      data_bus_in    = (i == n - 1) ? d  : 8'($urandom);
      @(negedge clock);
    end
    if (cs_end) chip_select_n  = 1'b1;
    else        write_enable_n = 1'b1;
    address     = 1'($urandom);
    data_bus_in = 8'($urandom);
    k = model_write(a0, d);
    exp_at[cyc + LAT] = model_snapshot(k);
    @(negedge clock);
    chip_select_n  = 1'b1;
    write_enable_n = 1'b1;
  endtask

  task automatic rst_pulse();
    idle(LAT + 1);
    reset = 1'b1;
    model_reset();
    exp_at[cyc + 1] = model_snapshot(0);
    idle(2);
    reset = 1'b0;
    idle(1);
  endtask

  // Reset lands in the middle of a write that is still active after reset releases
  task automatic rst_mid_write();
    idle(LAT + 1);
    chip_select_n  = 1'b0;
    write_enable_n = 1'b0;
    address        = 1'($urandom);
    data_bus_in    = 8'($urandom);
    idle(2);
    reset = 1'b1;
    model_reset();
    exp_at[cyc + 1] = model_snapshot(0);
    idle(2);
    reset = 1'b0;
    idle(4);
    chip_select_n  = 1'b1;
    write_enable_n = 1'b1;
    idle(LAT + 2);
  endtask

  int         r;
  logic       ra0;
  logic [7:0] rd;

  initial begin
    reset          = 1'b1;
    chip_select_n  = 1'b1;
    write_enable_n = 1'b1;
    address        = 1'b0;
    data_bus_in    = 8'h00;
    model_reset();
    idle(3);
    mon_en = 1'b1;
    reset  = 1'b0;
    idle(1);

    // Single mode with ICW4: ICW1, ICW2, ICW4
    wr(1'b0, 8'h13, 1, 1'b0);
    wr(1'b1, 8'h20, 2, 1'b0);
    wr(1'b1, 8'h01, 1, 1'b1);
    idle(LAT + 1);

    // Cascade with ICW4: ICW1..ICW4
    wr(1'b0, 8'h11, 1, 1'b0);
    wr(1'b1, 8'h08, 1, 1'b0);
    wr(1'b1, 8'h04, 3, 1'b1);
    wr(1'b1, 8'h1D, 1, 1'b0);
    idle(2);

    // OCW1 / OCW2 / OCW3 in READY, back-to-back with one idle cycle
    wr(1'b1, 8'hFF, 1, 1'b0);
    wr(1'b0, 8'h20, 1, 1'b0);
    wr(1'b0, 8'h0B, 1, 1'b1);

    // Dropped write in IDLE, then ICW1 clears the error, then OCW2 in WAIT_ICW2
    rst_pulse();
    wr(1'b1, 8'h55, 1, 1'b0);
    wr(1'b0, 8'h12, 1, 1'b0);
    wr(1'b0, 8'h20, 2, 1'b0);
    idle(2);

    // Restart mid-sequence with different configuration
    wr(1'b0, 8'h11, 1, 1'b0);
    wr(1'b1, 8'h30, 1, 1'b0);
    wr(1'b0, 8'h1A, 1, 1'b1);
    wr(1'b1, 8'h40, 1, 1'b0);
    idle(2);

    rst_mid_write();
    wr(1'b0, 8'h17, 1, 1'b0);

    // Randomized traffic
    for (int t = 0; t < 250; t++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        rst_mid_write();
      end else begin
        ra0 = 1'($urandom);
        rd  = 8'($urandom);
        if (r < 25) begin
          ra0   = 1'b0;
          rd[4] = 1'b1;
        end
        wr(ra0, rd, int'($urandom_range(1, 3)), 1'($urandom));
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      end
    end

    idle(LAT + 3);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/initialization_sequencer.md
# initialization_sequencer

Sequences the 8259A host-write protocol on a single clock. It detects completed CPU writes and decodes them into ICW1–ICW4 and OCW1–OCW3 write strobes. It tracks the ICW1→ICW2→[ICW3]→[ICW4] initialization order and supplies the latched data byte to the ICW and OCW register blocks. It sits between the bus interface and the command-word register modules in the control-logic partition.

## Interface
- No parameters.
- clock  in  1  system clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- chip_select_n  in  1  active-low chip select
- write_enable_n  in  1  active-low CPU write
- address  in  1  A0
- data_bus_in  in  8  CPU data D7..D0
- internal_data_bus  out  8  byte latched during the last completed write
- write_initial_command_word_1 .. _4  out  1 each  one-cycle ICW strobes
- write_operation_control_word_1 .. _3  out  1 each  one-cycle OCW strobes
- single_mode_config  out  1  ICW1 D1 (SNGL), latched on ICW1
- icw4_required  out  1  ICW1 D0 (IC4), latched on ICW1
- level_triggered_config  out  1  ICW1 D3 (LTIM), latched on ICW1
- initialization_done  out  1  high in READY
- sequence_error  out  1  sticky; set on a write dropped by the sequencer

## Operation
- Write active: chip_select_n==0 && write_enable_n==0, sampled each cycle.
- While a write is active, address and data_bus_in are captured every cycle into capture registers.
- Write completion is the first cycle where a write is no longer active after at least one active cycle. Decoding uses the captured values.
- Decode of a completed write:
  - A0=0, D4=1 → ICW1.
  - A0=0, D4=0, D3=0 → OCW2.
  - A0=0, D4=0, D3=1 → OCW3.
  - A0=1 → depends on state.
- States: IDLE (post-reset, uninitialized), WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY.
- ICW1 from any state:
  - Pulse ICW1.
  - Latch SNGL, IC4 and LTIM.
  - Go to WAIT_ICW2.
- A0=1 in WAIT_ICW2: pulse ICW2, then go to:
  - WAIT_ICW3 if !SNGL;
  - else WAIT_ICW4 if IC4;
  - else READY.
- A0=1 in WAIT_ICW3: pulse ICW3; go to WAIT_ICW4 if IC4, else READY.
- A0=1 in WAIT_ICW4: pulse ICW4; go to READY.
- A0=1 in READY: pulse OCW1.
- OCW2/OCW3 pulse only in READY.
- Dropped writes, with no strobe and no state change, set sequence_error:
  - any non-ICW1 write in IDLE;
  - OCW2/OCW3 decodes in any WAIT_* state.
- sequence_error is cleared by reset or by ICW1.
- At most one strobe is high in any cycle.
- internal_data_bus updates in the same cycle the strobe asserts and holds until the next completed write.

## Timing
- Reset values:
  - state IDLE;
  - all strobes 0;
  - internal_data_bus 8'h00;
  - single_mode_config, icw4_required, level_triggered_config 0;
  - initialization_done 0;
  - sequence_error 0.
- Latency: the strobe is registered and asserts in the cycle after write completion is sampled. It is high for exactly one cycle.
- A write active for one cycle only is still a valid write.
- Back-to-back writes with one idle cycle between them produce two strobes, two cycles apart.
- chip_select_n rising while write_enable_n is still low ends the write. It is decoded like a write_enable_n rise.
- Reset asserted mid-write or mid-sequence:
  - everything returns to reset values;
  - the pending write is discarded with no strobe;
  - a write still active when reset deasserts is ignored until it ends and a new write begins.
- ICW1 in the middle of a sequence restarts the sequence immediately.

## Configuration
- INIT_SEQ_WR_SYNC_EN defined:
  - chip_select_n, write_enable_n, address and data_bus_in pass through a two-flop synchronizer before write detection;
  - strobe latency becomes 3 cycles after the write ends;
  - synchronizer flops reset to inactive (1 for the _n inputs, 0 for the others).
- INIT_SEQ_WR_SYNC_EN undefined: inputs are used directly; latency is 1 cycle.

## Structure
- Package init_sequencer_pkg holds:
  - the state enum (IDLE, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY);
  - bit-index constants ICW1_IC4=0, ICW1_SNGL=1, ICW1_LTIM=3, ICW1_SEL=4, OCW3_SEL=3.
- One sub-module, write_completion_detector, contains:
  - the optional synchronizer;
  - the capture registers;
  - the active-to-inactive edge detect.
- It outputs write_done, captured_address and captured_data.

## Test plan
- Reset, then ICW1=8'h13 (SNGL=1, IC4=1), A0=1 8'h20, A0=1 8'h01 → ICW1, ICW2, ICW4 strobes in order with no ICW3. initialization_done=1 after the ICW4 strobe. internal_data_bus=8'h01.
- ICW1=8'h11 (cascade, IC4=1), then A0=1 writes 8'h08, 8'h04, 8'h1D → ICW2, ICW3, ICW4 strobes; then READY.
- In READY: A0=1 8'hFF → OCW1; A0=0 8'h20 → OCW2; A0=0 8'h0B → OCW3; each is a single one-cycle strobe.
- Sequence, IDLE part: after reset, A0=1 8'h55 → no strobe, sequence_error=1.
- Sequence, WAIT_ICW2 part: ICW1=8'h12 → sequence_error=0; then A0=0 8'h20 while in WAIT_ICW2 → no strobe, sequence_error=1.
- Restart and reset: ICW1, ICW2, then ICW1 again → state WAIT_ICW2 with new SNGL/IC4. Reset asserted during an active write → no strobe and all outputs at reset values.
